// File: rtl/score_controller_if.sv
// Score controller bus: groups the per-frame game events driven into the score
// controller and the registered score/ball status it drives back out.
//
// Signals
//   frame_tick   one-cycle pulse per video frame
//   start        one-cycle pulse requesting a new game
//   goal_left    one-cycle pulse, left player scored
//   goal_right   one-cycle pulse, right player scored
//   pause        level; present only with SCORE_CONTROLLER_PAUSE_EN defined
//   score_left   left score, 0..9
//   score_right  right score, 0..9
//   ball_enable  high while the ball may move
//   serve_dir    next serve: 0 = toward left, 1 = toward right
//   game_over    high while the game is finished
//   winner       valid while game_over: 0 = left, 1 = right
//
// Modports: master = game logic / event source, slave = score controller.
// Optional feature macro: SCORE_CONTROLLER_PAUSE_EN adds the pause signal.

interface score_controller_if;
  logic       frame_tick;
  logic       start;
  logic       goal_left;
  logic       goal_right;
`ifdef SCORE_CONTROLLER_PAUSE_EN
  logic       pause;
`endif
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       ball_enable;
  logic       serve_dir;
  logic       game_over;
  logic       winner;

`ifdef SCORE_CONTROLLER_PAUSE_EN
  modport master (
    output frame_tick, start, goal_left, goal_right, pause,
    input  score_left, score_right, ball_enable, serve_dir, game_over, winner
  );
  modport slave (
    input  frame_tick, start, goal_left, goal_right, pause,
    output score_left, score_right, ball_enable, serve_dir, game_over, winner
  );
`else
  modport master (
    output frame_tick, start, goal_left, goal_right,
    input  score_left, score_right, ball_enable, serve_dir, game_over, winner
  );
  modport slave (
    input  frame_tick, start, goal_left, goal_right,
    output score_left, score_right, ball_enable, serve_dir, game_over, winner
  );
`endif
endinterface

// File: rtl/score_controller.sv
// Score controller for a two-player ball game.
//
// Tracks both scores, holds the ball for HOLD_FRAMES frames after each goal,
// ends the game when a player reaches WIN_SCORE and restarts on start.
// Every output is a register, so outputs follow the causing input by one clk.
//
// Parameters
//   WIN_SCORE    point total that ends the game (1..9)
//   HOLD_FRAMES  frames the ball is held after a goal (1..255)
//
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    score_controller_if.slave (events in, score/ball status out)
//
// Optional feature macro: SCORE_CONTROLLER_PAUSE_EN adds the level input
// bus.pause. While high in PLAY or HOLD the ball is stopped and goals and
// frame ticks are ignored; state, scores and hold counter stay frozen.

module score_controller #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input logic              clk,
  input logic              reset,
  score_controller_if.slave bus
);

  localparam logic [3:0] WinScore = 4'(WIN_SCORE);
  localparam logic [7:0] HoldInit = 8'(HOLD_FRAMES);

  typedef enum logic [1:0] {StIdle, StPlay, StHold, StOver} state_t;

  state_t     state_q;
  logic [3:0] score_left_q;
  logic [3:0] score_right_q;
  logic [7:0] hold_cnt_q;
  logic       ball_enable_q;
  logic       serve_dir_q;
  logic       game_over_q;
  logic       winner_q;

  // run is low while play is paused; without the pause feature it is tied high
  // and folds away.
  logic run;
`ifdef SCORE_CONTROLLER_PAUSE_EN
  assign run = ~bus.pause;
`else
  assign run = 1'b1;
`endif

  // Single goal this cycle; a simultaneous pair is discarded as ambiguous.
  logic only_left;
  logic only_right;
  assign only_left  = bus.goal_left & ~bus.goal_right;
  assign only_right = bus.goal_right & ~bus.goal_left;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      score_left_q  <= 4'd0;
      score_right_q <= 4'd0;
      hold_cnt_q    <= 8'd0;
      ball_enable_q <= 1'b0;
      serve_dir_q   <= 1'b0;
      game_over_q   <= 1'b0;
      winner_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q       <= StPlay;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            ball_enable_q <= 1'b1;
            serve_dir_q   <= 1'b0;
            game_over_q   <= 1'b0;
          end
        end

        StPlay: begin
          if (!run) begin
            ball_enable_q <= 1'b0;
          end else if (only_left) begin
            ball_enable_q <= 1'b0;
            serve_dir_q   <= 1'b1;
            // Guard keeps the score from ever passing WIN_SCORE.
            if (score_left_q < WinScore) begin
              score_left_q <= score_left_q + 4'd1;
            end
            if (score_left_q + 4'd1 >= WinScore) begin
              state_q     <= StOver;
              game_over_q <= 1'b1;
              winner_q    <= 1'b0;
            end else begin
              state_q    <= StHold;
              hold_cnt_q <= HoldInit;
            end
          end else if (only_right) begin
            ball_enable_q <= 1'b0;
            serve_dir_q   <= 1'b0;
            if (score_right_q < WinScore) begin
              score_right_q <= score_right_q + 4'd1;
            end
            if (score_right_q + 4'd1 >= WinScore) begin
              state_q     <= StOver;
              game_over_q <= 1'b1;
              winner_q    <= 1'b1;
            end else begin
              state_q    <= StHold;
              hold_cnt_q <= HoldInit;
            end
          end else begin
            // Also re-enables the ball on the cycle after a pause is released.
            ball_enable_q <= 1'b1;
          end
        end

        StHold: begin
          ball_enable_q <= 1'b0;
          if (run && bus.frame_tick) begin
            if (hold_cnt_q <= 8'd1) begin
              state_q       <= StPlay;
              hold_cnt_q    <= 8'd0;
              ball_enable_q <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_q - 8'd1;
            end
          end
        end

        StOver: begin
          ball_enable_q <= 1'b0;
          if (bus.start) begin
            state_q       <= StPlay;
            score_left_q  <= 4'd0;
            score_right_q <= 4'd0;
            ball_enable_q <= 1'b1;
            game_over_q   <= 1'b0;
            // The loser serves: serve toward the side that lost.
            serve_dir_q   <= ~winner_q;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.score_left  = score_left_q;
  assign bus.score_right = score_right_q;
  assign bus.ball_enable = ball_enable_q;
  assign bus.serve_dir   = serve_dir_q;
  assign bus.game_over   = game_over_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_score_controller.sv
// Bench for score_controller: directed scenarios followed by random event
// traffic, all outputs compared each cycle against a behavioural game model.

module tb_score_controller;

  localparam int unsigned WinScore   = 9;
  localparam int unsigned HoldFrames = 3;

  logic clk = 1'b0;
  logic reset;

  score_controller_if bus ();

  score_controller #(
    .WIN_SCORE  (WinScore),
    .HOLD_FRAMES(HoldFrames)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural model: game phase expressed as started/over flags plus frames
  // still to wait before the ball may move again.
  int m_left, m_right, m_hold;
  bit m_started, m_over, m_winner, m_serve, m_pz;

  int n_asserts = 0;
  int n_fail    = 0;

  function automatic bit m_ball();
    return m_started && !m_over && (m_hold == 0) && !m_pz;
  endfunction

  function automatic void model_reset();
    m_left = 0; m_right = 0; m_hold = 0;
    m_started = 0; m_over = 0; m_winner = 0; m_serve = 0; m_pz = 0;
  endfunction

  function automatic void model_step(bit gl, bit gr, bit st, bit tk, bit pz);
    if (!m_started) begin
      if (st) begin
        m_started = 1; m_left = 0; m_right = 0; m_serve = 0;
      end
      m_pz = 0;
    end else if (m_over) begin
      if (st) begin
        m_over = 0; m_left = 0; m_right = 0; m_serve = !m_winner;
      end
      m_pz = 0;
    end else if (pz) begin
      m_pz = 1;
    end else begin
      m_pz = 0;
      if (m_hold > 0) begin
        if (tk) m_hold = m_hold - 1;
      end else if (gl != gr) begin
        if (gl) begin m_left = m_left + 1; m_serve = 1; end
        else begin m_right = m_right + 1; m_serve = 0; end
        if (m_left == WinScore || m_right == WinScore) begin
          m_over = 1; m_winner = gr;
        end else begin
          m_hold = HoldFrames;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".score_left"},  8'(bus.score_left),  8'(m_left));
    check({ctx, ".score_right"}, 8'(bus.score_right), 8'(m_right));
    check({ctx, ".ball_enable"}, 8'(bus.ball_enable), 8'(m_ball()));
    check({ctx, ".serve_dir"},   8'(bus.serve_dir),   8'(m_serve));
    check({ctx, ".game_over"},   8'(bus.game_over),   8'(m_over));
    if (m_over) check({ctx, ".winner"}, 8'(bus.winner), 8'(m_winner));
  endtask

  task automatic set_inputs(bit gl, bit gr, bit st, bit tk, bit pz);
    bus.goal_left  = gl;
    bus.goal_right = gr;
    bus.start      = st;
    bus.frame_tick = tk;
`ifdef SCORE_CONTROLLER_PAUSE_EN
    bus.pause      = pz;
`endif
  endtask

  // One clock: drive inputs away from the edge, advance the model at the
  // edge, then sample 1 time unit after it.
  task automatic step(input string ctx, bit gl, bit gr, bit st, bit tk, bit pz);
    set_inputs(gl, gr, st, tk, pz);
    @(posedge clk);
    model_step(gl, gr, st, tk, pz);
    #1;
    set_inputs(0, 0, 0, 0, pz);
    check_all(ctx);
  endtask

  initial begin
    reset = 1'b1;
    set_inputs(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // Idle ignores goals and ticks until start.
    step("idle_goal", 1, 0, 0, 1, 0);
    step("idle_right", 0, 1, 0, 0, 0);
    step("start", 0, 0, 1, 0, 0);
    step("play_start_ign", 0, 0, 1, 0, 0);
    step("both_goals", 1, 1, 0, 0, 0);

    // Left goal, hold for exactly HoldFrames ticks with idle cycles between.
    step("goal_left", 1, 0, 0, 0, 0);
    step("hold_goal_ign", 0, 1, 0, 0, 0);
    step("hold_start_ign", 0, 0, 1, 0, 0);
    for (int i = 0; i < int'(HoldFrames); i++) begin
      step("hold_idle", 0, 0, 0, 0, 0);
      step("hold_tick", 0, 0, 0, 1, 0);
    end
    step("play_tick_ign", 0, 0, 0, 1, 0);

    // Right wins; further goals ignored; restart serves toward the loser.
    for (int g = 0; g < int'(WinScore); g++) begin
      step("right_goal", 0, 1, 0, 0, 0);
      if (!m_over) for (int t = 0; t < int'(HoldFrames); t++) step("right_hold", 0, 0, 0, 1, 0);
    end
    step("over_goal_ign", 0, 1, 0, 1, 0);
    step("over_left_ign", 1, 0, 0, 0, 0);
    step("over_restart", 0, 0, 1, 0, 0);

    // Build 4/2 then reset asynchronously mid-hold.
    for (int g = 0; g < 6; g++) begin
      step("build", (g < 4) ? 1'b1 : 1'b0, (g >= 4) ? 1'b1 : 1'b0, 0, 0, 0);
      if (g != 5) for (int t = 0; t < int'(HoldFrames); t++) step("build_hold", 0, 0, 0, 1, 0);
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
    step("post_reset", 0, 0, 0, 1, 0);
    step("post_reset_goal", 1, 0, 0, 0, 0);

`ifdef SCORE_CONTROLLER_PAUSE_EN
    step("p_start", 0, 0, 1, 0, 0);
    step("p_goal", 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("p_paused", i[0], ~i[0], 0, 1, 1);
    check("p_hold_cnt", dut.hold_cnt_q, 8'(m_hold));
    for (int t = 0; t < int'(HoldFrames); t++) step("p_resume", 0, 0, 0, 1, 0);
    step("p_play_pause", 1, 0, 0, 0, 1);
    step("p_play_resume", 0, 0, 0, 0, 0);
`endif

    // Random traffic, with a reset now and then.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("rnd_reset");
        @(negedge clk);
        reset = 1'b0;
      end
      step("rnd",
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 2) == 0),
`ifdef SCORE_CONTROLLER_PAUSE_EN
           ($urandom_range(0, 7) == 0)
`else
           1'b0
`endif
      );
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
